// File: rtl/apb_slave_regfile_if.sv
// APB completer bus bundle (8-bit address and data). The master drives the request
// side; the slave returns the registered response.
interface apb_slave_regfile_if;
  logic       P_sel;
  logic       P_enable;
  logic       P_write;
  logic [7:0] P_addr;
  logic [7:0] P_wdata;
  logic [7:0] P_rdata;
  logic       P_ready;
  logic       P_slverr;

  modport master (
    output P_sel, P_enable, P_write, P_addr, P_wdata,
    input  P_rdata, P_ready, P_slverr
  );

  modport slave (
    input  P_sel, P_enable, P_write, P_addr, P_wdata,
    output P_rdata, P_ready, P_slverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a DEPTH x 8 register file and WAIT_CYCLES wait states per transfer.
// All responses are registered; P_ready stays high for one cycle per transfer.
module apb_slave_regfile #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  P_clk,
  input  logic                  P_reset_n,
  apb_slave_regfile_if.slave    bus
);
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;
  logic       slverr_q, slverr_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] regs_q [DEPTH];
  logic [7:0] regs_d [DEPTH];
  logic       wr_en;
  logic       setup_err;

  function automatic logic [AW-1:0] idx(input logic [7:0] a);
    return a[AW-1:0];
  endfunction

  assign setup_err = ({1'b0, bus.P_addr} >= DEPTH_W);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = 8'h00;
    wr_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.P_sel && !bus.P_enable) begin
          addr_d  = bus.P_addr;
          wdata_d = bus.P_wdata;
          write_d = bus.P_write;
          err_d   = setup_err;
          if (WAIT_CYCLES == 0) begin
            // No wait states: the response is built straight from the setup-phase bus.
            state_d  = ST_RESP;
            ready_d  = 1'b1;
            slverr_d = setup_err;
            rdata_d  = (!bus.P_write && !setup_err) ? regs_q[idx(bus.P_addr)] : 8'h00;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!bus.P_sel) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (bus.P_enable) begin
          if (cnt_q == 4'd0) begin
            state_d  = ST_RESP;
            ready_d  = 1'b1;
            slverr_d = err_q;
            rdata_d  = (!write_q && !err_q) ? regs_q[idx(addr_q)] : 8'h00;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        wr_en   = bus.P_sel && bus.P_enable && write_q && !err_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[idx(addr_q)] = wdata_q;
  end

  always_ff @(posedge P_clk) begin
    if (!P_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
      regs_q   <= regs_d;
    end
  end

  assign bus.P_ready  = ready_q;
  assign bus.P_slverr = slverr_q;
  assign bus.P_rdata  = rdata_q;
endmodule
